// File: rtl/xunit_sha_pkg.sv
// Shared SHA-256 constants, FSM encoding and bit functions for the xunit family
// (xunit_compress and xunitM).
package xunit_sha_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_ROUND = 2'd2,
    ST_FINAL = 2'd3
  } state_t;

  localparam logic [31:0] K_TAB [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] IV_TAB [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  // Message-schedule sigmas, used by xunitM.
  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 round: working variables a..h in, next a..h out.
module sha256_round
  import xunit_sha_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [31:0] i_c,
  input  logic [31:0] i_d,
  input  logic [31:0] i_e,
  input  logic [31:0] i_f,
  input  logic [31:0] i_g,
  input  logic [31:0] i_h,
  input  logic [31:0] i_k,
  input  logic [31:0] i_w,
  output logic [31:0] o_a,
  output logic [31:0] o_b,
  output logic [31:0] o_c,
  output logic [31:0] o_d,
  output logic [31:0] o_e,
  output logic [31:0] o_f,
  output logic [31:0] o_g,
  output logic [31:0] o_h
);

  logic [31:0] w_t1;
  logic [31:0] w_t2;

  assign w_t1 = i_h + big_sigma1(i_e) + ch(i_e, i_f, i_g) + i_k + i_w;
  assign w_t2 = big_sigma0(i_a) + maj(i_a, i_b, i_c);

  assign o_a = w_t1 + w_t2;
  assign o_b = i_a;
  assign o_c = i_b;
  assign o_d = i_c;
  assign o_e = i_d + w_t1;
  assign o_f = i_e;
  assign o_g = i_f;
  assign o_h = i_g;

endmodule

// File: rtl/xunit_compress.sv
// SHA-256 compression unit: one round per cycle over a W[t] stream, then the
// feed-forward add into H0..H7. A run pulse always restarts the block.
module xunit_compress
  import xunit_sha_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int DELAY_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic              done,
  input  logic [DATA_W-1:0] in0,
  output logic [DATA_W-1:0] out0,
  output logic [DATA_W-1:0] out1,
  output logic [DATA_W-1:0] out2,
  output logic [DATA_W-1:0] out3,
  output logic [DATA_W-1:0] out4,
  output logic [DATA_W-1:0] out5,
  output logic [DATA_W-1:0] out6,
  output logic [DATA_W-1:0] out7,
  input  logic [7:0]        configDelay,
  input  logic              configInit
);

  state_t              r_state;
  logic                r_done;
  logic [DELAY_W-1:0]  r_delay;
  logic [5:0]          r_t;
  logic [7:0][31:0]    r_h;      // index 0 = H0
  logic [7:0][31:0]    r_w;      // index 0 = a, 7 = h
  logic [7:0][31:0]    w_h_start;
  logic [7:0][31:0]    w_w_next;

  // Working registers start from the IV or from the current digest (chaining).
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_start
      assign w_h_start[gi] = configInit ? IV_TAB[gi] : r_h[gi];
    end
  endgenerate

  sha256_round u_round (
    .i_a (r_w[0]), .i_b (r_w[1]), .i_c (r_w[2]), .i_d (r_w[3]),
    .i_e (r_w[4]), .i_f (r_w[5]), .i_g (r_w[6]), .i_h (r_w[7]),
    .i_k (K_TAB[r_t]),
    .i_w (in0),
    .o_a (w_w_next[0]), .o_b (w_w_next[1]), .o_c (w_w_next[2]), .o_d (w_w_next[3]),
    .o_e (w_w_next[4]), .o_f (w_w_next[5]), .o_g (w_w_next[6]), .o_h (w_w_next[7])
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_done  <= 1'b1;
      r_delay <= '0;
      r_t     <= '0;
      r_h     <= '0;
      r_w     <= '0;
    end else if (run) begin
      // Restart from any state; an in-flight block is dropped without its final add.
      r_delay <= DELAY_W'(configDelay);
      r_t     <= '0;
      r_w     <= w_h_start;
      if (configInit) r_h <= w_h_start;
      r_done  <= 1'b0;
      r_state <= (configDelay != 8'd0) ? ST_DELAY : ST_ROUND;
    end else begin
      case (r_state)
        ST_DELAY: begin
          r_delay <= r_delay - DELAY_W'(1);
          if (r_delay == DELAY_W'(1)) r_state <= ST_ROUND;
        end
        ST_ROUND: begin
          r_w <= w_w_next;
          r_t <= r_t + 6'd1;
          if (r_t == 6'd63) r_state <= ST_FINAL;
        end
        ST_FINAL: begin
          for (int i = 0; i < 8; i++) r_h[i] <= r_h[i] + r_w[i];
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: begin
        end
      endcase
    end
  end

  assign done = r_done;
  assign out0 = r_h[0];
  assign out1 = r_h[1];
  assign out2 = r_h[2];
  assign out3 = r_h[3];
  assign out4 = r_h[4];
  assign out5 = r_h[5];
  assign out6 = r_h[6];
  assign out7 = r_h[7];

endmodule

// File: tb/tb_xunit_compress.sv
// Self-checking bench for xunit_compress: a textbook SHA-256 model with a
// cycle countdown is compared against the DUT on every falling edge.
module tb_xunit_compress;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        done;
  logic [31:0] in0 = 32'h0;
  logic [31:0] out0, out1, out2, out3, out4, out5, out6, out7;
  logic [7:0]  configDelay = 8'd0;
  logic        configInit = 1'b0;

  always #5 clk = ~clk;

  xunit_compress #(.DATA_W(32), .DELAY_W(10)) dut (
    .clk(clk), .rst(rst), .run(run), .done(done), .in0(in0),
    .out0(out0), .out1(out1), .out2(out2), .out3(out3),
    .out4(out4), .out5(out5), .out6(out6), .out7(out7),
    .configDelay(configDelay), .configInit(configInit)
  );

  localparam logic [31:0] KB [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [31:0] IVB [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };
  localparam logic [255:0] ABC_D = {32'hf20015ad, 32'hb410ff61, 32'h96177a9c, 32'hb00361a3,
                                    32'h5dae2223, 32'h414140de, 32'h8f01cfea, 32'hba7816bf};
  localparam logic [255:0] TWO_D = {32'h19db06c1, 32'hf6ecedd4, 32'h64ff2167, 32'ha33ce459,
                                    32'h0c3e6039, 32'he5c02693, 32'hd20638b8, 32'h248d6a61};

  int n_checks = 0;
  int n_pass   = 0;
  int m_rem    = 0;          // cycles until the model says done
  int cyc_since_run = 0;
  logic [7:0][31:0] m_h  = '0;  // index 0 = H0
  logic [7:0][31:0] m_pend = '0;
  logic [31:0] msg [0:15];
  logic [31:0] blk_w [0:63];
  wire  [255:0] dut_h = {out7, out6, out5, out4, out3, out2, out1, out0};

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // FIPS 180-4 message expansion of msg[] into blk_w[].
  task automatic expand();
    for (int t = 0; t < 64; t++) begin
      if (t < 16) blk_w[t] = msg[t];
      else blk_w[t] = (rr(blk_w[t-2], 17) ^ rr(blk_w[t-2], 19) ^ (blk_w[t-2] >> 10)) + blk_w[t-7]
                    + (rr(blk_w[t-15], 7) ^ rr(blk_w[t-15], 18) ^ (blk_w[t-15] >> 3)) + blk_w[t-16];
    end
  endtask

  // Textbook compression of blk_w[] into a chaining value.
  task automatic model_compress(input logic [7:0][31:0] hin, output logic [7:0][31:0] hout);
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    {h, g, f, e, d, c, b, a} = hin;
    for (int t = 0; t < 64; t++) begin
      t1 = h + (rr(e, 6) ^ rr(e, 11) ^ rr(e, 25)) + ((e & f) ^ (~e & g)) + KB[t] + blk_w[t];
      t2 = (rr(a, 2) ^ rr(a, 13) ^ rr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    hout[0] = hin[0] + a; hout[1] = hin[1] + b; hout[2] = hin[2] + c; hout[3] = hin[3] + d;
    hout[4] = hin[4] + e; hout[5] = hin[5] + f; hout[6] = hin[6] + g; hout[7] = hin[7] + h;
  endtask

  // One clock edge; the model follows what the DUT sampled at that edge.
  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      if (run) begin
        if (configInit) for (int i = 0; i < 8; i++) m_h[i] = IVB[i];
        model_compress(m_h, m_pend);
        m_rem = int'(configDelay) + 65;
        cyc_since_run = 0;
      end else begin
        cyc_since_run++;
        if (m_rem > 0) begin
          m_rem--;
          if (m_rem == 0) m_h = m_pend;
        end
      end
    end
    #1;
  endtask

  task automatic start(input logic init, input logic [7:0] dly);
    configInit = init; configDelay = dly; run = 1'b1;
    tick();
    run = 1'b0; configInit = 1'($urandom); configDelay = 8'($urandom);
  endtask

  task automatic feed(input int dly, input int n);
    for (int i = 0; i < dly; i++) begin in0 = $urandom; tick(); end
    for (int t = 0; t < n; t++) begin in0 = blk_w[t]; tick(); end
    in0 = $urandom;
  endtask

  task automatic finish_block(input string name, input int exp_lat);
    int guard = 0;
    while (done !== 1'b1 && guard < 300) begin tick(); guard++; end
    check({name, "_latency"}, 256'(cyc_since_run), 256'(exp_lat));
    tick(); tick();
  endtask

  task automatic load_abc();
    for (int i = 0; i < 16; i++) msg[i] = 32'h0;
    msg[0] = 32'h61626380; msg[15] = 32'h00000018;
    expand();
  endtask

  always @(negedge clk) begin
    check("done", 256'(done), 256'(m_rem == 0));
    check("digest", dut_h, m_h);
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    #7;
    check("reset_done", 256'(done), 256'(1));
    check("reset_out", dut_h, 256'(0));
    rst = 1'b0;
    tick(); tick();

    load_abc();
    start(1'b1, 8'd0); feed(0, 64); finish_block("abc", 65);
    check("abc_digest", dut_h, ABC_D);
    $display("abc block: digest %h", dut_h);

    msg = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
            32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
            32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
            32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    expand();
    start(1'b1, 8'd0); feed(0, 64); finish_block("two_a", 65);
    for (int i = 0; i < 16; i++) msg[i] = 32'h0;
    msg[15] = 32'h000001c0;
    expand();
    start(1'b0, 8'd0); feed(0, 64); finish_block("two_b", 65);
    check("two_digest", dut_h, TWO_D);
    $display("two-block message: digest %h", dut_h);

    load_abc();
    start(1'b1, 8'd3); feed(3, 64); finish_block("abc_dly3", 68);
    check("abc_dly3_digest", dut_h, ABC_D);
    $display("abc delay 3: digest %h", dut_h);

    load_abc();
    start(1'b1, 8'd0); feed(0, 20);
    start(1'b1, 8'd0); feed(0, 64); finish_block("restart", 65);
    check("restart_digest", dut_h, ABC_D);
    $display("restart at t=20: digest %h", dut_h);

    // Run landing on the FINAL edge: H must keep the IV and chain from it.
    start(1'b1, 8'd0); feed(0, 64);
    for (int t = 0; t < 64; t++) blk_w[t] = $urandom;
    start(1'b0, 8'd1); feed(1, 64); finish_block("run_at_final", 66);
    $display("run at FINAL: digest %h", dut_h);

    load_abc();
    start(1'b1, 8'd0); feed(0, 30);
    rst = 1'b1; m_h = '0; m_rem = 0;
    #1;
    check("midrst_done", 256'(done), 256'(1));
    check("midrst_out", dut_h, 256'(0));
    rst = 1'b0;
    tick();
    start(1'b1, 8'd0); feed(0, 64); finish_block("after_rst", 65);
    check("after_rst_digest", dut_h, ABC_D);
    $display("reset at t=30 then abc: digest %h", dut_h);

    for (int k = 0; k < 10; k++) begin
      int dly;
      int cut;
      dly = (k == 4) ? 20 : int'($urandom_range(0, 5));
      cut = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63)) : 64;
      for (int t = 0; t < 64; t++) blk_w[t] = $urandom;
      start(1'((k == 0) || ($urandom_range(0, 1) == 1)), 8'(dly));
      feed(dly, cut);
      if (cut == 64) begin
        finish_block("rand", dly + 65);
        $display("random block %0d: delay %0d digest %h", k, dly, dut_h);
      end else begin
        $display("random block %0d: delay %0d aborted after %0d words", k, dly, cut);
      end
    end
    for (int t = 0; t < 64; t++) blk_w[t] = $urandom;
    start(1'b1, 8'd2); feed(2, 64); finish_block("last", 67);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
